// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   localparam int PC_I    = 0;
   localparam int IFID_I  = 1;
   localparam int IDEX_I  = 2;
   localparam int EXMEM_I = 3;
   localparam int WB_I    = 4;
   localparam int NSTG    = WB_I + 1;

   localparam logic [NSTG-1:0] EN_ALL        = '1;
   localparam logic [NSTG-1:0] EN_NONE       = '0;
   localparam logic [NSTG-1:0] FLUSH_NONE    = '0;
   // Branch squashes the two younger instructions already fetched/decoded.
   localparam logic [NSTG-1:0] FLUSH_BRANCH  = NSTG'((1 << IFID_I) | (1 << IDEX_I));
   localparam logic [NSTG-1:0] FLUSH_LOADUSE = NSTG'(1 << IDEX_I);
   localparam logic [NSTG-1:0] EN_LOADUSE    = NSTG'((1 << IDEX_I) | (1 << EXMEM_I) | (1 << WB_I));

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment, clear+inc loads 1.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         sat
);

   assign sat = &q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (clear)
         q <= inc ? W'(1) : '0;
      else if (inc && !sat)
         q <= q + 1'b1;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-register CPU pipeline with
// memory-wait timeout, terminal halt and a saturating stall counter.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_use,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   input  logic             halt_req,
   output logic [NSTG-1:0]  en,
   output logic [NSTG-1:0]  flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
   // The counter holds completed wait cycles; the one now ending is the last
   // allowed when the count including it reaches MEM_TIMEOUT.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_t          state, nxt;
   logic [TO_W-1:0] to_q;
   logic            to_sat, to_clr, to_inc, err_set;
   logic            stall_inc, stall_sat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         mem_err <= 1'b0;
      end else begin
         state <= nxt;
         if (err_set) mem_err <= 1'b1;
      end
   end

   always_comb begin
      nxt     = state;
      en      = EN_NONE;
      flush   = FLUSH_NONE;
      to_clr  = 1'b0;
      to_inc  = 1'b0;
      err_set = 1'b0;
      case (state)
         RUN: begin
            // A same-cycle ack is a zero-wait access and decodes normally.
            if (mem_req && !mem_ack) begin
               nxt    = MEM_WAIT;
               to_clr = 1'b1;
               to_inc = 1'b1;
            end else if (halt_req) begin
               nxt = HALT;
            end else if (branch_taken) begin
               en    = EN_ALL;
               flush = FLUSH_BRANCH;
            end else if (load_use) begin
               en    = EN_LOADUSE;
               flush = FLUSH_LOADUSE;
            end else begin
               en = EN_ALL;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               en  = EN_ALL;
               nxt = RUN;
            end else if (to_q == TO_LAST || to_sat) begin
               nxt     = HALT;
               err_set = 1'b1;
            end else begin
               to_inc = 1'b1;
            end
         end
         HALT: ;
         default: nxt = RUN;
      endcase
      if (reset) begin
         en    = EN_NONE;
         flush = FLUSH_NONE;
      end
   end

   assign halted    = (state == HALT);
   assign stall_inc = !en[PC_I] && (state != HALT);

   sat_counter #(.W(TO_W)) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clear (to_clr),
      .inc   (to_inc),
      .q     (to_q),
      .sat   (to_sat)
   );

   sat_counter #(.W(CNT_W)) u_stall (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (stall_inc),
      .q     (stall_cnt),
      .sat   (stall_sat)
   );

   logic unused_ok;
   assign unused_ok = stall_sat;

endmodule
